sram_responder: RTL

SRAM_RESPONDER -- requirements
Module: sram_responder

---
 rtl/sram_responder_pkg.sv | 30 +++
 rtl/sram_responder_bank.sv | 38 +++
 rtl/sram_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sram_responder_pkg.sv
// Shared constants for the SRAM responder: MMIO register map,
// unmapped-read word and the byte-lane merge helper.
package sram_responder_pkg;

    localparam logic [31:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [1:0] REG_TIMER    = 2'd0;
    localparam logic [1:0] REG_STATUS   = 2'd1;
    localparam logic [1:0] REG_SCRATCH0 = 2'd2;
    localparam logic [1:0] REG_SCRATCH1 = 2'd3;

    typedef enum logic {
        SRC_HOLD = 1'b0,
        SRC_BANK = 1'b1
    } resp_src_e;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_responder_bank.sv
// Dual-port word array: port A read-only, port B read/write with byte
// enables. Both ports read-first with a registered output.
module sram_bank #(
    parameter int unsigned AW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_en,
    input  logic [AW-1:0] a_addr,
    output logic [31:0]   a_rdata,
    input  logic          b_en,
    input  logic [3:0]    b_wen,
    input  logic [AW-1:0] b_addr,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (b_en) begin
            for (int i = 0; i < 4; i++) begin
                if (b_wen[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= 32'd0;
            b_rdata <= 32'd0;
        end else begin
            if (a_en) a_rdata <= mem[a_addr];
            if (b_en) b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Instruction/data SRAM responder: address decode, MMIO timer/status/
// scratch registers and sticky unmapped-access error.
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 14,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE  = 32'h1FAF_0000,
    parameter logic [31:0] ERR_WORD   = ERR_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        err_sticky
);

    logic [DEPTH_LOG2-1:0] i_idx, d_idx;
    logic        i_mem, d_mem, d_mmio;
    logic        i_go, d_go, d_wr;
    logic [1:0]  d_reg;
    logic [31:0] i_bank_q, d_bank_q, mmio_rd;
    logic [31:0] timer, scratch0, scratch1;
    logic [31:0] i_hold, d_hold;
    resp_src_e   i_src, d_src;
    logic        err_set, err_clr;
    logic        unused;

    assign unused = ^{inst_sram_wen, inst_sram_wdata,
                      inst_sram_addr[1:0], data_sram_addr[1:0]};

    assign i_idx  = inst_sram_addr[DEPTH_LOG2+1:2];
    assign d_idx  = data_sram_addr[DEPTH_LOG2+1:2];
    assign i_mem  = inst_sram_addr[31:DEPTH_LOG2+2] == MEM_BASE[31:DEPTH_LOG2+2];
    assign d_mem  = data_sram_addr[31:DEPTH_LOG2+2] == MEM_BASE[31:DEPTH_LOG2+2];
    // Memory wins if a misconfigured MMIO page overlaps the array.
    assign d_mmio = ~d_mem & (data_sram_addr[31:4] == MMIO_BASE[31:4]);
    assign d_reg  = data_sram_addr[3:2];

    assign i_go = inst_sram_en & ~rst;
    assign d_go = data_sram_en & ~rst;
    assign d_wr = |data_sram_wen;

    assign err_set = (i_go & ~i_mem) | (d_go & ~d_mem & ~d_mmio);
    assign err_clr = d_go & d_mmio & d_wr & (d_reg == REG_STATUS);

    always_comb begin
        mmio_rd = timer;
        unique case (d_reg)
            REG_TIMER:    mmio_rd = timer;
            REG_STATUS:   mmio_rd = {31'b0, err_sticky};
            REG_SCRATCH0: mmio_rd = scratch0;
            REG_SCRATCH1: mmio_rd = scratch1;
        endcase
    end

    sram_bank #(
        .AW(DEPTH_LOG2)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .a_en    (i_go & i_mem),
        .a_addr  (i_idx),
        .a_rdata (i_bank_q),
        .b_en    (d_go & d_mem),
        .b_wen   (data_sram_wen),
        .b_addr  (d_idx),
        .b_wdata (data_sram_wdata),
        .b_rdata (d_bank_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer      <= 32'd0;
            scratch0   <= 32'd0;
            scratch1   <= 32'd0;
            err_sticky <= 1'b0;
            i_hold     <= 32'd0;
            d_hold     <= 32'd0;
            i_src      <= SRC_HOLD;
            d_src      <= SRC_HOLD;
        end else begin
            timer <= timer + 32'd1;
            if (err_set)      err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
            if (i_go) begin
                i_src <= i_mem ? SRC_BANK : SRC_HOLD;
                if (!i_mem) i_hold <= ERR_WORD;
            end
            if (d_go) begin
                d_src <= d_mem ? SRC_BANK : SRC_HOLD;
                if (d_mmio)      d_hold <= mmio_rd;
                else if (!d_mem) d_hold <= ERR_WORD;
                if (d_mmio && d_wr) begin
                    unique case (d_reg)
                        REG_TIMER:
                            timer <= byte_merge(timer, data_sram_wdata, data_sram_wen);
                        REG_SCRATCH0:
                            scratch0 <= byte_merge(scratch0, data_sram_wdata, data_sram_wen);
                        REG_SCRATCH1:
                            scratch1 <= byte_merge(scratch1, data_sram_wdata, data_sram_wen);
                        REG_STATUS: ;
                    endcase
                end
            end
        end
    end

    assign inst_sram_rdata = (i_src == SRC_BANK) ? i_bank_q : i_hold;
    assign data_sram_rdata = (d_src == SRC_BANK) ? d_bank_q : d_hold;

endmodule
